// File: rtl/climate_pkg.sv
// Shared types and helpers for the greenhouse climate controller.
package climate_pkg;

  localparam int unsigned SP_W = 8;

  localparam logic [1:0] ADJ_NONE = 2'd0;
  localparam logic [1:0] ADJ_UP   = 2'd1;
  localparam logic [1:0] ADJ_DOWN = 2'd2;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_HEAT = 2'd1,
    T_COOL = 2'd2,
    T_LOCK = 2'd3
  } tstate_t;

  // Bits needed to hold 0..limit inclusive.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return $clog2(limit + 1);
  endfunction

  // One saturating setpoint step; codes other than up/down leave it unchanged.
  function automatic logic [SP_W-1:0] step_sp(input logic [SP_W-1:0] sp,
                                              input logic [1:0]      adj,
                                              input logic [SP_W-1:0] lo,
                                              input logic [SP_W-1:0] hi);
    logic [SP_W-1:0] res;
    res = sp;
    if (adj == ADJ_UP && sp < hi) begin
      res = sp + SP_W'(1);
    end else if (adj == ADJ_DOWN && sp > lo) begin
      res = sp - SP_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/climate_ctrl_if.sv
// Sensor/menu inputs and actuator/status outputs of the climate controller.
interface climate_ctrl_if;
  import climate_pkg::*;

  logic [1:0]      temp_adjust;
  logic [1:0]      hum_adjust;
  logic [SP_W-1:0] temp_in;
  logic [SP_W-1:0] hum_in;
  logic            sample_valid;
  logic            tick_1hz;
  logic [SP_W-1:0] temp_sp;
  logic [SP_W-1:0] hum_sp;
  logic            heater_on;
  logic            fan_on;
  logic            mister_on;
  tstate_t         tstate;
  logic            fault;

  modport master (
    output temp_adjust, hum_adjust, temp_in, hum_in, sample_valid, tick_1hz,
    input  temp_sp, hum_sp, heater_on, fan_on, mister_on, tstate, fault
  );

  modport slave (
    input  temp_adjust, hum_adjust, temp_in, hum_in, sample_valid, tick_1hz,
    output temp_sp, hum_sp, heater_on, fan_on, mister_on, tstate, fault
  );
endinterface

// File: rtl/sat_tick_cnt.sv
// Tick counter that saturates at LIMIT; clr has priority over tick.
module sat_tick_cnt #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned LIMIT   = 10,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             done
);

  logic [WIDTH-1:0] count_nxt;

  // Next count: clear, or step until the limit is reached.
  always_comb begin
    count_nxt = count;
    if (clr) begin
      count_nxt = '0;
    end else if (tick && count < WIDTH'(LIMIT)) begin
      count_nxt = count + WIDTH'(1);
    end
  end

  // Count and its registered limit flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= WIDTH'(RST_VAL);
      done  <= (RST_VAL >= LIMIT);
    end else begin
      count <= count_nxt;
      done  <= (count_nxt >= WIDTH'(LIMIT));
    end
  end

endmodule

// File: rtl/climate_ctrl.sv
// Greenhouse climate controller: saturating setpoints, temperature FSM with
// hysteresis / min run / min off / heat-cool interlock, humidity mister/vent.
// Optional sensor watchdog enabled by defining CLIMATE_FAILSAFE_EN.
module climate_ctrl
  import climate_pkg::*;
#(
  parameter int unsigned TEMP_DEF   = 72,
  parameter int unsigned TEMP_MIN   = 40,
  parameter int unsigned TEMP_MAX   = 100,
  parameter int unsigned HUM_DEF    = 50,
  parameter int unsigned HUM_MIN    = 10,
  parameter int unsigned HUM_MAX    = 90,
  parameter int unsigned HYST       = 2,
  parameter int unsigned MIN_RUN    = 10,
  parameter int unsigned MIN_OFF    = 5,
  parameter int unsigned WDOG_TICKS = 30
) (
  input logic            clk,
  input logic            rst,
  climate_ctrl_if.slave  bus
);

  localparam int unsigned RUN_W = cnt_width(MIN_RUN);
  localparam int unsigned OFF_W = cnt_width(MIN_OFF);

  logic [SP_W-1:0] temp_sp_q, hum_sp_q;
  tstate_t         tstate_q, tstate_nxt;
  logic            heater_q, fan_q, mister_q, vent_q;
  logic            mister_nxt, vent_nxt;
  logic [8:0]      t9, t_sp9, t_lo, t_hi, h9, h_sp9, h_lo, h_hi;
  logic            run_clr, run_tick, run_done, off_clr, off_tick, off_done;
  logic [RUN_W-1:0] run_cnt;
  logic [OFF_W-1:0] off_cnt;
  logic            unused_cnt;

  // Setpoint registers stepped by the menu adjust codes.
  always_ff @(posedge clk) begin
    if (rst) begin
      temp_sp_q <= SP_W'(TEMP_DEF);
      hum_sp_q  <= SP_W'(HUM_DEF);
    end else begin
      temp_sp_q <= step_sp(temp_sp_q, bus.temp_adjust, SP_W'(TEMP_MIN), SP_W'(TEMP_MAX));
      hum_sp_q  <= step_sp(hum_sp_q,  bus.hum_adjust,  SP_W'(HUM_MIN),  SP_W'(HUM_MAX));
    end
  end

  // Thresholds widened to 9 bits so sp+HYST never wraps.
  always_comb begin
    t9    = 9'(bus.temp_in);
    t_sp9 = 9'(temp_sp_q);
    t_lo  = t_sp9 - 9'(HYST);
    t_hi  = t_sp9 + 9'(HYST);
    h9    = 9'(bus.hum_in);
    h_sp9 = 9'(hum_sp_q);
    h_lo  = h_sp9 - 9'(HYST);
    h_hi  = h_sp9 + 9'(HYST);
  end

`ifdef CLIMATE_FAILSAFE_EN
  localparam int unsigned WD_W = cnt_width(WDOG_TICKS);
  logic            fault_q, fault_nxt, wd_done;
  logic [WD_W-1:0] wd_cnt;
`endif

  // Next temp state and humidity flags, evaluated only on a sensor sample.
  always_comb begin
    tstate_nxt = tstate_q;
    mister_nxt = mister_q;
    vent_nxt   = vent_q;
    if (bus.sample_valid) begin
      if (h9 < h_lo)        mister_nxt = 1'b1;
      else if (h9 >= h_sp9) mister_nxt = 1'b0;
      if (h9 > h_hi)        vent_nxt = 1'b1;
      else if (h9 <= h_sp9) vent_nxt = 1'b0;
    end
    case (tstate_q)
      T_IDLE: begin
        if (bus.sample_valid && off_done) begin
          if (t9 < t_lo)      tstate_nxt = T_HEAT;
          else if (t9 > t_hi) tstate_nxt = T_COOL;
        end
      end
      T_HEAT: if (bus.sample_valid && t9 >= t_sp9 && run_done) tstate_nxt = T_LOCK;
      T_COOL: if (bus.sample_valid && t9 <= t_sp9 && run_done) tstate_nxt = T_LOCK;
      default: tstate_nxt = T_IDLE;
    endcase
`ifdef CLIMATE_FAILSAFE_EN
    fault_nxt = fault_q;
    if (fault_q) begin
      if (bus.sample_valid) begin
        fault_nxt  = 1'b0;
        tstate_nxt = T_IDLE;
      end else begin
        tstate_nxt = T_LOCK;
        mister_nxt = 1'b0;
        vent_nxt   = 1'b0;
      end
    end else if (wd_done && !bus.sample_valid) begin
      fault_nxt  = 1'b1;
      tstate_nxt = T_LOCK;
      mister_nxt = 1'b0;
      vent_nxt   = 1'b0;
    end
`endif
  end

  // Temp FSM state and registered actuator drives.
  always_ff @(posedge clk) begin
    if (rst) begin
      tstate_q <= T_IDLE;
      heater_q <= 1'b0;
      fan_q    <= 1'b0;
      mister_q <= 1'b0;
      vent_q   <= 1'b0;
    end else begin
      tstate_q <= tstate_nxt;
      heater_q <= (tstate_nxt == T_HEAT);
      fan_q    <= (tstate_nxt == T_COOL) | vent_nxt;
      mister_q <= mister_nxt;
      vent_q   <= vent_nxt;
    end
  end

  // Run time restarts on entry to HEAT/COOL; off time restarts while locked.
  assign run_clr  = (tstate_nxt != tstate_q) && (tstate_nxt == T_HEAT || tstate_nxt == T_COOL);
  assign run_tick = bus.tick_1hz && (tstate_q == T_HEAT || tstate_q == T_COOL);
  assign off_clr  = (tstate_q == T_LOCK);
  assign off_tick = bus.tick_1hz && (tstate_q == T_IDLE);

  sat_tick_cnt #(.WIDTH(RUN_W), .LIMIT(MIN_RUN), .RST_VAL(0)) u_run_cnt (
    .clk(clk), .rst(rst), .clr(run_clr), .tick(run_tick), .count(run_cnt), .done(run_done)
  );

  sat_tick_cnt #(.WIDTH(OFF_W), .LIMIT(MIN_OFF), .RST_VAL(MIN_OFF)) u_off_cnt (
    .clk(clk), .rst(rst), .clr(off_clr), .tick(off_tick), .count(off_cnt), .done(off_done)
  );

`ifdef CLIMATE_FAILSAFE_EN
  sat_tick_cnt #(.WIDTH(WD_W), .LIMIT(WDOG_TICKS), .RST_VAL(0)) u_wd_cnt (
    .clk(clk), .rst(rst), .clr(bus.sample_valid), .tick(bus.tick_1hz), .count(wd_cnt), .done(wd_done)
  );

  // Watchdog fault flag.
  always_ff @(posedge clk) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_nxt;
  end

  assign bus.fault  = fault_q;
  assign unused_cnt = ^{run_cnt, off_cnt, wd_cnt};
`else
  assign bus.fault  = 1'b0;
  assign unused_cnt = ^{run_cnt, off_cnt};
`endif

  assign bus.temp_sp   = temp_sp_q;
  assign bus.hum_sp    = hum_sp_q;
  assign bus.heater_on = heater_q;
  assign bus.fan_on    = fan_q;
  assign bus.mister_on = mister_q;
  assign bus.tstate    = tstate_q;

endmodule

// File: tb/tb_climate_ctrl.sv
// Directed self-checking bench for climate_ctrl.
module tb_climate_ctrl;
  import climate_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  climate_ctrl_if bus ();

  climate_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic pulse_sample(input logic [7:0] t, input logic [7:0] h);
    bus.temp_in      = t;
    bus.hum_in       = h;
    bus.sample_valid = 1'b1;
    cyc();
    bus.sample_valid = 1'b0;
  endtask

  task automatic pulse_tick();
    bus.tick_1hz = 1'b1;
    cyc();
    bus.tick_1hz = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.temp_sp !== 8'd72) begin n_err++; $display("FAIL reset_temp_sp: got %0d want 72", bus.temp_sp); end
    n_cmp++; if (bus.hum_sp !== 8'd50) begin n_err++; $display("FAIL reset_hum_sp: got %0d want 50", bus.hum_sp); end
    n_cmp++; if ({bus.heater_on, bus.fan_on, bus.mister_on} !== 3'b000) begin n_err++; $display("FAIL reset_drives: got %b want 000", {bus.heater_on, bus.fan_on, bus.mister_on}); end
    n_cmp++; if (bus.tstate !== T_IDLE) begin n_err++; $display("FAIL reset_tstate: got %0d want 0", bus.tstate); end
    n_cmp++; if (bus.fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b want 0", bus.fault); end
  endtask

  task automatic test_setpoint_sat();
    do_reset();
    bus.temp_adjust = 2'd1;
    repeat (35) cyc();
    bus.temp_adjust = 2'd0;
    n_cmp++; if (bus.temp_sp !== 8'd100) begin n_err++; $display("FAIL temp_sp_max: got %0d want 100", bus.temp_sp); end
    bus.temp_adjust = 2'd2;
    repeat (70) cyc();
    bus.temp_adjust = 2'd0;
    n_cmp++; if (bus.temp_sp !== 8'd40) begin n_err++; $display("FAIL temp_sp_min: got %0d want 40", bus.temp_sp); end
    bus.temp_adjust = 2'd3;
    cyc();
    bus.temp_adjust = 2'd0;
    n_cmp++; if (bus.temp_sp !== 8'd40) begin n_err++; $display("FAIL temp_sp_code3: got %0d want 40", bus.temp_sp); end
    bus.hum_adjust = 2'd1;
    repeat (45) cyc();
    bus.hum_adjust = 2'd0;
    n_cmp++; if (bus.hum_sp !== 8'd90) begin n_err++; $display("FAIL hum_sp_max: got %0d want 90", bus.hum_sp); end
    bus.hum_adjust = 2'd2;
    repeat (3) cyc();
    bus.hum_adjust = 2'd0;
    n_cmp++; if (bus.hum_sp !== 8'd87) begin n_err++; $display("FAIL hum_sp_down: got %0d want 87", bus.hum_sp); end
  endtask

  task automatic test_heat_cycle();
    do_reset();
    pulse_sample(8'd70, 8'd50);
    n_cmp++; if (bus.heater_on !== 1'b0) begin n_err++; $display("FAIL heat_edge_band: got %b want 0", bus.heater_on); end
    pulse_sample(8'd69, 8'd50);
    n_cmp++; if (bus.heater_on !== 1'b1) begin n_err++; $display("FAIL heat_start: got %b want 1", bus.heater_on); end
    n_cmp++; if (bus.tstate !== T_HEAT) begin n_err++; $display("FAIL heat_state: got %0d want 1", bus.tstate); end
    repeat (3) pulse_tick();
    pulse_sample(8'd72, 8'd50);
    n_cmp++; if (bus.heater_on !== 1'b1) begin n_err++; $display("FAIL heat_min_run: got %b want 1", bus.heater_on); end
    repeat (6) pulse_tick();
    pulse_sample(8'd72, 8'd50);
    n_cmp++; if (bus.heater_on !== 1'b1) begin n_err++; $display("FAIL heat_9_ticks: got %b want 1", bus.heater_on); end
    pulse_tick();
    pulse_sample(8'd72, 8'd50);
    n_cmp++; if (bus.heater_on !== 1'b0) begin n_err++; $display("FAIL heat_stop: got %b want 0", bus.heater_on); end
    n_cmp++; if (bus.tstate !== T_LOCK) begin n_err++; $display("FAIL heat_lock: got %0d want 3", bus.tstate); end
    cyc();
    n_cmp++; if (bus.tstate !== T_IDLE) begin n_err++; $display("FAIL lock_to_idle: got %0d want 0", bus.tstate); end
  endtask

  // Follows test_heat_cycle: off timer was just cleared by T_LOCK.
  task automatic test_cool_min_off();
    for (int i = 0; i < 5; i++) begin
      pulse_sample(8'd80, 8'd50);
      n_cmp++; if (bus.fan_on !== 1'b0) begin n_err++; $display("FAIL cool_min_off_%0d: got %b want 0", i, bus.fan_on); end
      n_cmp++; if (bus.heater_on & bus.fan_on) begin n_err++; $display("FAIL interlock_%0d: got heater=%b fan=%b want not both", i, bus.heater_on, bus.fan_on); end
      pulse_tick();
    end
    pulse_sample(8'd80, 8'd50);
    n_cmp++; if (bus.fan_on !== 1'b1) begin n_err++; $display("FAIL cool_start: got %b want 1", bus.fan_on); end
    n_cmp++; if (bus.heater_on !== 1'b0) begin n_err++; $display("FAIL cool_heater_off: got %b want 0", bus.heater_on); end
    n_cmp++; if (bus.tstate !== T_COOL) begin n_err++; $display("FAIL cool_state: got %0d want 2", bus.tstate); end
  endtask

  task automatic test_humidity();
    do_reset();
    pulse_sample(8'd72, 8'd47);
    n_cmp++; if (bus.mister_on !== 1'b1) begin n_err++; $display("FAIL mister_set: got %b want 1", bus.mister_on); end
    pulse_sample(8'd72, 8'd49);
    n_cmp++; if (bus.mister_on !== 1'b1) begin n_err++; $display("FAIL mister_hold: got %b want 1", bus.mister_on); end
    pulse_sample(8'd72, 8'd50);
    n_cmp++; if (bus.mister_on !== 1'b0) begin n_err++; $display("FAIL mister_clear: got %b want 0", bus.mister_on); end
    pulse_sample(8'd72, 8'd52);
    n_cmp++; if (bus.fan_on !== 1'b0) begin n_err++; $display("FAIL vent_band: got %b want 0", bus.fan_on); end
    pulse_sample(8'd72, 8'd53);
    n_cmp++; if (bus.fan_on !== 1'b1) begin n_err++; $display("FAIL vent_set: got %b want 1", bus.fan_on); end
    n_cmp++; if (bus.mister_on !== 1'b0) begin n_err++; $display("FAIL vent_mister_excl: got %b want 0", bus.mister_on); end
    pulse_sample(8'd72, 8'd50);
    n_cmp++; if (bus.fan_on !== 1'b0) begin n_err++; $display("FAIL vent_clear: got %b want 0", bus.fan_on); end
  endtask

  task automatic test_adjust_with_sample();
    do_reset();
    bus.temp_adjust = 2'd1;
    pulse_sample(8'd69, 8'd50);
    bus.temp_adjust = 2'd0;
    n_cmp++; if (bus.heater_on !== 1'b1) begin n_err++; $display("FAIL same_cycle_heat: got %b want 1", bus.heater_on); end
    n_cmp++; if (bus.temp_sp !== 8'd73) begin n_err++; $display("FAIL same_cycle_sp: got %0d want 73", bus.temp_sp); end
  endtask

  task automatic test_watchdog();
    do_reset();
    pulse_sample(8'd69, 8'd50);
    repeat (29) pulse_tick();
    cyc();
    n_cmp++; if (bus.fault !== 1'b0) begin n_err++; $display("FAIL wd_29_ticks: got %b want 0", bus.fault); end
    pulse_tick();
    cyc();
`ifdef CLIMATE_FAILSAFE_EN
    n_cmp++; if (bus.fault !== 1'b1) begin n_err++; $display("FAIL wd_fault: got %b want 1", bus.fault); end
    n_cmp++; if ({bus.heater_on, bus.fan_on, bus.mister_on} !== 3'b000) begin n_err++; $display("FAIL wd_drives: got %b want 000", {bus.heater_on, bus.fan_on, bus.mister_on}); end
    repeat (3) cyc();
    n_cmp++; if (bus.tstate !== T_LOCK) begin n_err++; $display("FAIL wd_hold_lock: got %0d want 3", bus.tstate); end
    pulse_sample(8'd72, 8'd50);
    n_cmp++; if (bus.fault !== 1'b0) begin n_err++; $display("FAIL wd_clear: got %b want 0", bus.fault); end
    n_cmp++; if (bus.tstate !== T_IDLE) begin n_err++; $display("FAIL wd_resume_idle: got %0d want 0", bus.tstate); end
`else
    n_cmp++; if (bus.fault !== 1'b0) begin n_err++; $display("FAIL fault_tied: got %b want 0", bus.fault); end
    n_cmp++; if (bus.heater_on !== 1'b1) begin n_err++; $display("FAIL no_wd_heat: got %b want 1", bus.heater_on); end
`endif
  endtask

  task automatic test_reset_mid_heat();
    do_reset();
    bus.temp_adjust = 2'd1;
    cyc();
    bus.temp_adjust = 2'd0;
    pulse_sample(8'd69, 8'd45);
    n_cmp++; if ({bus.heater_on, bus.mister_on} !== 2'b11) begin n_err++; $display("FAIL pre_rst_drives: got %b want 11", {bus.heater_on, bus.mister_on}); end
    rst = 1'b1;
    cyc();
    n_cmp++; if ({bus.heater_on, bus.mister_on} !== 2'b00) begin n_err++; $display("FAIL rst_mid_drives: got %b want 00", {bus.heater_on, bus.mister_on}); end
    n_cmp++; if (bus.temp_sp !== 8'd72) begin n_err++; $display("FAIL rst_mid_sp: got %0d want 72", bus.temp_sp); end
    n_cmp++; if (bus.tstate !== T_IDLE) begin n_err++; $display("FAIL rst_mid_state: got %0d want 0", bus.tstate); end
    rst = 1'b0;
    cyc();
  endtask

  initial begin
    rst              = 1'b1;
    bus.temp_adjust  = 2'd0;
    bus.hum_adjust   = 2'd0;
    bus.temp_in      = 8'd72;
    bus.hum_in       = 8'd50;
    bus.sample_valid = 1'b0;
    bus.tick_1hz     = 1'b0;
    test_reset();
    test_setpoint_sat();
    test_heat_cycle();
    test_cool_min_off();
    test_humidity();
    test_adjust_with_sample();
    test_watchdog();
    test_reset_mid_heat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
